// File: rtl/sequential_ripple_adder_32bit.sv
// Multi-cycle adder: latches A/B/c_in on start, then adds one DIGIT-wide slice
// per clock (LSB first) and publishes sum/c_out with a one-cycle done pulse.
module sequential_ripple_adder_32bit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy,
  output logic             done
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;

  int               bit_idx;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   dig_sum;

  // Next-state and datapath for the latch / digit-serial add / publish sequence
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    bit_idx = int'(cnt_q) * DIGIT;
    a_dig   = a_q[bit_idx +: DIGIT];
    b_dig   = b_q[bit_idx +: DIGIT];
    dig_sum = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          cnt_d   = '0;
          carry_d = c_in;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[bit_idx +: DIGIT] = dig_sum[DIGIT-1:0];
        carry_d                 = dig_sum[DIGIT];
        if (cnt_q == LAST_DIG) begin
          // Final digit: publish the freshly completed accumulator, not acc_q
          sum_d   = acc_d;
          c_out_d = dig_sum[DIGIT];
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: doc/sequential_ripple_adder_32bit.md
SEQUENTIAL_RIPPLE_ADDER_32BIT -- requirements
Module: sequential_ripple_adder_32bit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have parameter: DIGIT, 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: start  input  1  request to begin an addition.
REQ-006 SHALL have port: A  input  WIDTH  augend.
REQ-007 SHALL have port: B  input  WIDTH  addend.
REQ-008 SHALL have port: c_in  input  1  carry-in.
REQ-009 SHALL have port: sum  output  WIDTH  registered result A+B+c_in, modulo 2^WIDTH.
REQ-010 SHALL have port: c_out  output  1  registered carry-out of the full-width addition.
REQ-011 SHALL have port: busy  output  1  high while an addition is in progress.
REQ-012 SHALL have port: done  output  1  one-cycle pulse marking that sum/c_out were just updated.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at a rising edge SHALL latch A, B, c_in into internal registers, clear digit counter, load internal carry with c_in, go to RUN; start=0 stays in IDLE.
REQ-015 RUN: each cycle SHALL add digit n (bits n*DIGIT+DIGIT-1 : n*DIGIT) of latched A and B plus internal carry, store the DIGIT-bit result into digit n of an internal accumulator, update internal carry, increment counter; LSB digit first.
REQ-016 RUN SHALL last exactly WIDTH/DIGIT cycles (8 at defaults); on the edge processing the last digit, the full accumulator SHALL be copied to sum, final carry to c_out, and FSM SHALL go to DONE.
REQ-017 DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
REQ-018 Latency: start sampled at edge k SHALL produce updated sum/c_out and done=1 after edge k+WIDTH/DIGIT (k+8 at defaults); next start accepted at edge k+WIDTH/DIGIT+2 (in IDLE).
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; both 0 in IDLE.
REQ-020 start SHALL be ignored in RUN and DONE; no re-latching, no effect on result in flight.
REQ-021 A, B, c_in changes after the latch edge SHALL NOT affect the result in flight.
REQ-022 sum and c_out SHALL change only on the completion edge (REQ-016) or reset, holding their value otherwise, including through subsequent RUN cycles.
REQ-023 Overflow: carry out of bit WIDTH-1 SHALL appear only on c_out; sum wraps modulo 2^WIDTH.
REQ-024 Boundary: A=B=0, c_in=0 SHALL yield sum=0, c_out=0 with normal latency and done pulse (no early termination).

Reset
REQ-025 rst_n=0 at a rising edge SHALL force FSM to IDLE, sum=0, c_out=0, busy=0, done=0, clear counter, internal carry, latched operands, accumulator.
REQ-026 Reset SHALL take priority over start and over any in-flight operation; an aborted addition SHALL produce no done pulse and no sum/c_out update.
REQ-027 start=1 coincident with rst_n=0 SHALL be ignored; start must be re-asserted after reset release.

Verification
REQ-028 A=0x00000007, B=0x00000005, c_in=0, start pulse -> busy 8 cycles, then done=1 one cycle with sum=0x0000000C, c_out=0.
REQ-029 A=0x00000007, B=0x00000005, c_in=1 -> sum=0x0000000D, c_out=0; A=0x00000101, B=0x00000017, c_in=0 -> sum=0x00000118, c_in=1 -> sum=0x00000119.
REQ-030 A=0xFFFFFFFF, B=0x00000000, c_in=1 -> sum=0x00000000, c_out=1 (carry ripples across all 8 digits); A=0x80000000, B=0x80000000, c_in=0 -> sum=0, c_out=1.
REQ-031 Start 0x7+0x5, then during RUN assert start with A=0xFFFFFFFF, B=0x1 and change A/B every cycle -> exactly one done pulse, sum=0x0000000C; no second operation begins.
REQ-032 Start 0x101+0x17, drive rst_n=0 at 4th RUN cycle -> next cycle busy=0, done=0, sum=0, c_out=0; no done pulse for 20 cycles; fresh start afterwards yields 0x00000118 with normal latency.
REQ-033 Back-to-back: start held high continuously -> operations begin every 10 cycles (latch, 8 RUN, DONE), each done pulse one cycle wide, sum correct per latched operands.
